// File: rtl/pixel_window_shifter.sv
// Sliding 8-tap pixel window generator: pairs consecutive input words (prev|cur)
// and presents the eight windows starting at pixel offsets 0..7 of that pair.
module pixel_window_shifter #(
   parameter int PIX_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [8*PIX_W-1:0] in_pixels,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [8*PIX_W-1:0] out_window,
   output logic [2:0]         out_idx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         word_cnt
);

   localparam int WORD_W = 8 * PIX_W;

   typedef enum logic [1:0] {
      PRIME = 2'd0,
      FILL  = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   prev_q, prev_d;
   logic [WORD_W-1:0]   cur_q, cur_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          cnt_q;
   logic [2*WORD_W-1:0] concat;
   logic                in_xfer;
   logic                out_xfer;
   logic                last_window;

   assign last_window = (idx_q == 3'd7);

   // EMIT only takes a new word while the last window of the pair leaves, so
   // back-to-back words stream without a bubble.
   assign out_valid = (state_q == EMIT);
   assign in_ready  = !flush && ((state_q != EMIT) || (last_window && out_ready));
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready && !flush;

   // Concat pixel c is prev pixel c for c<8 and cur pixel c-8 otherwise.
   assign concat     = {cur_q, prev_q};
   assign out_window = WORD_W'(concat >> (int'(idx_q) * PIX_W));
   assign out_idx    = idx_q;
   assign word_cnt   = cnt_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis would infer latches.
      state_d = state_q;
      prev_d  = prev_q;
      cur_d   = cur_q;
      idx_d   = idx_q;

      unique case (state_q)
         PRIME: begin
            if (in_xfer) begin
               cur_d   = in_pixels;
               state_d = FILL;
            end
         end
         FILL: begin
            if (in_xfer) begin
               prev_d  = cur_q;
               cur_d   = in_pixels;
               idx_d   = 3'd0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (!last_window) begin
                  idx_d = idx_q + 3'd1;
               end else begin
                  prev_d = cur_q;
                  idx_d  = 3'd0;
                  if (in_xfer) begin
                     cur_d = in_pixels;
                  end else begin
                     state_d = FILL;
                  end
               end
            end
         end
         default: begin
            state_d = PRIME;
            prev_d  = '0;
            cur_d   = '0;
            idx_d   = 3'd0;
         end
      endcase

      // Flush discards everything buffered and overrides any transfer decision.
      if (flush) begin
         state_d = PRIME;
         prev_d  = '0;
         cur_d   = '0;
         idx_d   = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= PRIME;
         prev_q  <= '0;
         cur_q   <= '0;
         idx_q   <= 3'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         idx_q   <= idx_d;
         if (in_xfer) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   // A stalled window must not move until the consumer takes it.
   a_stall_hold : assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !flush) |=>
         (out_valid && $stable(out_window) && $stable(out_idx)));

   a_flush_blocks_input : assert property (@(posedge clk) disable iff (reset)
      flush |-> !in_ready);

endmodule

// File: tb/tb_pixel_window_shifter.sv
// Scoreboard bench for pixel_window_shifter: the driver queues expected windows
// per accepted word pair, an independent monitor pops them on output transfers.
module tb_pixel_window_shifter;

   localparam logic [63:0] WA = 64'h0706050403020100;
   localparam logic [63:0] WB = 64'h0F0E0D0C0B0A0908;
   localparam logic [63:0] WC = 64'h1716151413121110;

   typedef struct packed {
      logic [63:0] win;
      logic [2:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [63:0] in_pixels;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_window;
   logic [2:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  word_cnt;

   exp_t        sb[$];
   logic [63:0] last_word;
   bit          have_prev;
   int          checks = 0;
   int          errors = 0;
   int          run_len = 0;
   int          max_run = 0;

   pixel_window_shifter #(.PIX_W(8)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_pixels(in_pixels), .in_valid(in_valid), .in_ready(in_ready),
      .out_window(out_window), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Independent byte-level model of window k over the pair (p, c).
   function automatic logic [63:0] model_win(input logic [63:0] p, input logic [63:0] c, input int k);
      logic [7:0]  px [16];
      logic [63:0] r;
      for (int i = 0; i < 8; i++) begin
         px[i]   = p[8*i +: 8];
         px[i+8] = c[8*i +: 8];
      end
      r = '0;
      for (int j = 0; j < 8; j++) r[8*j +: 8] = px[k+j];
      return r;
   endfunction

   task automatic model_accept(input logic [63:0] w);
      exp_t e;
      if (have_prev) begin
         for (int k = 0; k < 8; k++) begin
            e.win = model_win(last_word, w, k);
            e.idx = 3'(k);
            sb.push_back(e);
         end
      end
      last_word = w;
      have_prev = 1'b1;
   endtask

   task automatic model_clear();
      sb.delete();
      have_prev = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the word is accepted.
   task automatic send_word(input logic [63:0] w, input bit chk_k7);
      int n = 0;
      in_pixels = w;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      if (in_ready) begin
         if (chk_k7) begin
            check("accept_at_k7_idx", 64'(out_idx), 64'd7);
            check("accept_at_k7_win", out_window, 64'h0E0D0C0B0A090807);
         end
         model_accept(w);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drain", 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_wait", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      model_clear();
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: an output transfer is sampled mid-cycle ahead of its edge.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window actual=%h idx=%0d required=none", out_window, out_idx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("window", out_window, e.win);
            check("window_idx", 64'(out_idx), 64'(e.idx));
         end
      end
   end

   always @(negedge clk) begin
      if (out_valid && !reset) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_pixels = '0; in_valid = 1'b0; out_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_idx", 64'(out_idx), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      check("rst_out_window", out_window, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // A then B: eight windows of A|B
      out_ready = 1'b1;
      send_word(WA, 1'b0);
      check("prime_no_valid", 64'(out_valid), 64'd0);
      send_word(WB, 1'b0);
      wait_drain();
      check("ab_word_cnt", 64'(word_cnt), 64'd2);
      check("ab_fill_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      do_flush();
      check("flush_keeps_cnt", 64'(word_cnt), 64'd2);

      // A, B, C back-to-back: C taken with k=7, 16 valid cycles in a row
      max_run = 0;
      send_word(WA, 1'b0);
      send_word(WB, 1'b0);
      send_word(WC, 1'b1);
      wait_drain();
      check("abc_run_length", 64'(max_run), 64'd16);
      check("abc_word_cnt", 64'(word_cnt), 64'd5);
      @(posedge clk);
      #1;
      do_flush();

      // Stall at k=3
      out_ready = 1'b0;
      send_word(WA, 1'b0);
      send_word(WB, 1'b0);
      wait_valid();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_window", out_window, 64'h0A09080706050403);
         check("stall_idx", 64'(out_idx), 64'd3);
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();
      check("stall_word_cnt", 64'(word_cnt), 64'd7);
      @(posedge clk);
      #1;

      // Flush at k=4, then C only primes
      do_reset();
      out_ready = 1'b0;
      send_word(WA, 1'b0);
      send_word(WB, 1'b0);
      wait_valid();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_flush_idx", 64'(out_idx), 64'd4);
      @(posedge clk);
      #1;
      do_flush();
      out_ready = 1'b1;
      @(negedge clk);
      check("post_flush_valid", 64'(out_valid), 64'd0);
      check("post_flush_idx", 64'(out_idx), 64'd0);
      @(posedge clk);
      #1;
      send_word(WC, 1'b0);
      repeat (10) begin
         @(negedge clk);
         check("c_primes_no_valid", 64'(out_valid), 64'd0);
      end
      check("flush_c_word_cnt", 64'(word_cnt), 64'd3);
      @(posedge clk);
      #1;

      // 256 words: counter wraps
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [63:0] w;
         for (int p = 0; p < 8; p++) w[8*p +: 8] = 8'(i * 3 + p * 17);
         send_word(w, 1'b0);
         if (i == 254) check("cnt_255", 64'(word_cnt), 64'd255);
      end
      wait_drain();
      check("cnt_wrap", 64'(word_cnt), 64'd0);
      @(posedge clk);
      #1;

      // Reset mid-EMIT
      send_word(WA, 1'b0);
      send_word(WB, 1'b0);
      wait_valid();
      do_reset();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_word_cnt", 64'(word_cnt), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_idx", 64'(out_idx), 64'd0);
      repeat (20) @(negedge clk);
      check("midrst_no_valid", 64'(out_valid), 64'd0);
      check("final_drain", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pixel_window_shifter.md
PIXEL_WINDOW_SHIFTER -- requirements
Module: pixel_window_shifter

Interface
REQ-001 SHALL have parameter: PIX_W, default 8, bits per pixel; each data word holds 8 pixels of PIX_W bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: flush  input  1  synchronous discard of buffered pixels; return to priming.
REQ-005 SHALL have port: in_pixels  input  8*PIX_W  input word; pixel p at bits [PIX_W*p+PIX_W-1 : PIX_W*p].
REQ-006 SHALL have port: in_valid  input  1  in_pixels valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts in_pixels this cycle.
REQ-008 SHALL have port: out_window  output  8*PIX_W  8-tap filter window, same pixel packing as in_pixels.
REQ-009 SHALL have port: out_idx  output  3  window start offset k (0..7).
REQ-010 SHALL have port: out_valid  output  1  out_window/out_idx valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts window this cycle.
REQ-012 SHALL have port: word_cnt  output  8  accepted input words modulo 256.

Function
REQ-013 SHALL complete an input transfer only when in_valid && in_ready, and an output transfer only when out_valid && out_ready.
REQ-014 SHALL hold registers prev and cur (8 pixels each); concat pixel c = prev pixel c for c<8, cur pixel c-8 for c>=8.
REQ-015 SHALL drive window k as out_window pixel j = concat pixel k+j, for j = 0..7.
REQ-016 SHALL implement states PRIME (no pixels held), FILL (prev held, waiting for next word) and EMIT (prev and cur held, windows pending).
REQ-017 PRIME SHALL assert in_ready=1 and out_valid=0; on transfer: cur<=in_pixels, move to FILL.
REQ-018 FILL SHALL assert in_ready=1 and out_valid=0; on transfer: prev<=cur, cur<=in_pixels, out_idx<=0, move to EMIT.
REQ-019 EMIT SHALL assert out_valid=1 and hold out_window/out_idx stable while out_ready=0.
REQ-020 EMIT with out_idx<7 and output transfer SHALL increment out_idx by 1.
REQ-021 EMIT in_ready SHALL equal (out_idx==7 && out_ready), combinationally.
REQ-022 EMIT with out_idx==7, output transfer and in_valid: prev<=cur, cur<=in_pixels, out_idx<=0, stay in EMIT (no bubble).
REQ-023 EMIT with out_idx==7, output transfer and !in_valid: prev<=cur, move to FILL.
REQ-024 SHALL produce first window (out_idx=0) one cycle after the transfer that enters EMIT.
REQ-025 SHALL increment word_cnt on every input transfer, wrapping 255->0.
REQ-026 flush=1 SHALL force in_ready=0 that cycle, accept no input, complete no output transfer, and next state SHALL be PRIME with out_valid=0 and out_idx=0.
REQ-027 flush SHALL NOT change word_cnt.
REQ-028 Any out_ready/in_valid activity while out_valid=0 SHALL have no effect beyond REQ-017/018.

Reset
REQ-029 reset=1 SHALL take priority over flush and all handshakes.
REQ-030 After reset: state PRIME, out_valid=0, out_idx=0, word_cnt=0, out_window=0, prev=cur=0.
REQ-031 Reset asserted mid-EMIT SHALL discard pending windows; no window is emitted for the pre-reset words.

Verification (PIX_W=8; A=64'h0706050403020100, B=64'h0F0E0D0C0B0A0908, C=64'h1716151413121110)
REQ-032 Send A then B, out_ready=1 -> 8 windows k=0..7; k=0 = 64'h0706050403020100, k=1 = 64'h0807060504030201, k=7 = 64'h0E0D0C0B0A090807; word_cnt=2.
REQ-033 Send A, B, C back-to-back, out_ready=1, in_valid=1 -> C accepted with window k=7 of the A|B pair; next cycle k=0 = B, k=1 = 64'h100F0E0D0C0B0A09; 16 consecutive valid cycles.
REQ-034 After A, B, hold out_ready=0 for 5 cycles at k=3 -> out_window stays 64'h0A09080706050403, out_idx=3, in_ready=0.
REQ-035 Assert flush at k=4 of A|B, then send C -> no window after flush; state PRIME; C only primes; out_valid=0; word_cnt=3.
REQ-036 Send 256 words -> word_cnt returns to 0; reset mid-EMIT -> next cycle out_valid=0, word_cnt=0, in_ready=1.
